// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 serial transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel load handshake plus serial line of the transmitter.
interface uart_tx_if;

  logic [7:0] d;
  logic       en;
  logic       ready;
  logic       busy;
  logic       tx;

  modport master (
    output d,
    output en,
    input  ready,
    input  busy,
    input  tx
  );

  modport slave (
    input  d,
    input  en,
    output ready,
    output busy,
    output tx
  );

endinterface

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: tick is high during the last clock of each serial bit.
module baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Held at zero while stopped so every frame starts on a full bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB-first, stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_START = 2'(START);
  localparam logic [1:0] S_DATA  = 2'(DATA);
  localparam logic [1:0] S_STOP  = 2'(STOP);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_badParam
    $error("uart_tx: CLKS_PER_BIT must be within 2..65535");
  end

  logic [1:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bitIdx;
  logic       r_tx;
  logic       r_ready;
  logic       r_busy;
  logic       w_run;
  logic       w_tick;

  assign w_run = (r_state != S_IDLE);

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .run (w_run),
    .tick(w_tick)
  );

  // Outputs are registered alongside the state, so tx always reflects the
  // level of the bit currently being driven with no path from en or d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= 8'h00;
      r_bitIdx <= 3'd0;
      r_tx     <= LINE_IDLE;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.en && r_ready) begin
            r_shift  <= bus.d;
            r_bitIdx <= 3'd0;
            r_tx     <= START_LEVEL;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bitIdx == LAST_BIT) begin
              r_tx    <= STOP_LEVEL;
              r_state <= S_STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[1];
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_tx    <= LINE_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= LINE_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx    = r_tx;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 and 2 clocks per bit.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] d;
  logic       useN2;
  int         nClk;
  int         assertCount = 0;
  int         failCount = 0;

  uart_tx_if bus4 ();
  uart_tx_if bus2 ();

  assign bus4.en = en && !useN2;
  assign bus4.d  = d;
  assign bus2.en = en && useN2;
  assign bus2.d  = d;

  logic obsTx, obsReady, obsBusy;
  assign obsTx    = useN2 ? bus2.tx    : bus4.tx;
  assign obsReady = useN2 ? bus2.ready : bus4.ready;
  assign obsBusy  = useN2 ? bus2.busy  : bus4.busy;

  uart_tx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  uart_tx #(.CLKS_PER_BIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_tx"}, {31'd0, obsTx}, 32'd1);
    checkOutput({tag, "_ready"}, {31'd0, obsReady}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, obsBusy}, 32'd0);
  endtask

  // Called at the falling edge right after the accepting edge; walks the frame
  // one clock at a time. pulseIdx >= 0 drives a stray load at that cycle.
  task automatic applyStimulus(input logic [7:0] b, input string tag,
                               input int pulseIdx, input logic [7:0] pulseD);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * nClk; i++) begin
      checkOutput($sformatf("%s_tx%0d", tag, i), {31'd0, obsTx}, {31'd0, frame[i / nClk]});
      if (i == 0 || i == 10 * nClk - 1) begin
        checkOutput($sformatf("%s_ready%0d", tag, i), {31'd0, obsReady}, 32'd0);
        checkOutput($sformatf("%s_busy%0d", tag, i), {31'd0, obsBusy}, 32'd1);
      end
      if (pulseIdx >= 0) begin
        en = (i == pulseIdx);
        d  = (i == pulseIdx) ? pulseD : 8'h00;
      end
      @(negedge clk);
    end
  endtask

  task automatic loadByte(input logic [7:0] b);
    en = 1'b1;
    d  = b;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    d  = 8'h00;
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    d     = 8'h00;
    useN2 = 1'b0;
    nClk  = 4;
    repeat (3) @(negedge clk);
    checkIdle("rst_init");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while idle, held for five cycles.
    #2 rst = 1'b1;
    #1 checkIdle("rst_async");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkIdle($sformatf("rst_hold%0d", i));
    end
    rst = 1'b0;
    @(negedge clk);

    // Single byte A5: line 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit.
    loadByte(8'hA5);
    applyStimulus(8'hA5, "a5", -1, 8'h00);
    checkIdle("a5_end");
    @(negedge clk);

    // Back-to-back 00 then FF with en held high throughout.
    en = 1'b1;
    d  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    d = 8'hFF;
    applyStimulus(8'h00, "b2b0", -1, 8'h00);
    checkIdle("b2b_gap");
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    applyStimulus(8'hFF, "b2b1", -1, 8'h00);
    checkIdle("b2b_end");
    @(negedge clk);

    // Stray load of C3 during the 3C frame must be ignored.
    loadByte(8'h3C);
    applyStimulus(8'h3C, "ign", 13, 8'hC3);
    checkIdle("ign_end");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ign_noframe%0d", i), {31'd0, obsTx}, 32'd1);
    end

    // Reset inside data bit 3 of 55, then a clean 81 frame.
    loadByte(8'h55);
    repeat (17) @(negedge clk);
    checkOutput("mid_bit3", {31'd0, obsTx}, 32'd0);
    checkOutput("mid_busy", {31'd0, obsBusy}, 32'd1);
    #2 rst = 1'b1;
    #1 checkIdle("mid_rst");
    @(negedge clk);
    checkIdle("mid_hold");
    rst = 1'b0;
    @(negedge clk);
    loadByte(8'h81);
    applyStimulus(8'h81, "post81", -1, 8'h00);
    checkIdle("post81_end");

    // Minimum rate: 2 clocks per bit, byte 01, 20-cycle frame.
    useN2 = 1'b1;
    nClk  = 2;
    @(negedge clk);
    checkIdle("n2_idle");
    loadByte(8'h01);
    applyStimulus(8'h01, "n2", -1, 8'h00);
    checkIdle("n2_end");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the 8-bit datapath: accepts a parallel byte on a load strobe and shifts it out as an 8N1 asynchronous frame (start bit, 8 data bits LSB-first, stop bit) on a single line. It sits between any 8-bit register/bus source and an off-chip serial pin, and is the outbound counterpart to the parallel-load register stage. Rate is set by a clocks-per-bit parameter; no fractional baud.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; elaboration error outside it.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  8  byte to transmit; sampled only on an accepted load.
- en  input  1  load strobe; accepted when en && ready on a rising clk edge.
- ready  output  1  high when a new byte can be accepted.
- busy  output  1  high while a frame is on the line; always equal to !ready.
- tx  output  1  serial line; idle level 1.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, ready=1. On en && ready: latch d into shift register, clear bit counter and baud counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift register bit 0; after CLKS_PER_BIT cycles shift right by one, increment bit index; after the 8th bit (index 7) completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- en while ready=0 is ignored; d is don't-care outside the accept cycle; the latched byte is not affected by later changes on d.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 on bit boundary; never runs in IDLE.
- Bit index: 3 bits, 0..7, no wrap past 7 (state change occurs first).
- Reset (any time, including mid-frame): state=IDLE, tx=1, ready=1, busy=0, shift register=8'h00, counters=0; the partial frame is abandoned, no stop bit generated.

## Timing
- tx, ready, busy are registered outputs (no combinational path from en/d).
- Accept on edge T: at T+1 ready=0, busy=1, tx=0 (start bit begins).
- Data bit k occupies cycles T+1+(k+1)*N .. T+(k+2)*N, N=CLKS_PER_BIT.
- Stop bit occupies T+1+9N .. T+10N; ready=1 from T+1+10N.
- Frame length exactly 10*N cycles; ready low for exactly 10*N cycles per accepted byte.
- Back-to-back: en held high with ready=1 at T+1+10N → next start bit begins at T+2+10N; minimum line idle between frames is 1 cycle.
- Reset asserted between edges forces outputs to reset values immediately (asynchronous), not at next edge; release is synchronous to the next clk edge.

## Structure
- Shared package uart_pkg: state enum type (IDLE, START, DATA, STOP), DATA_BITS=8, LINE_IDLE=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1. Same package is reused by the future receiver.
- One sub-module: baud_gen (parameter CLKS_PER_BIT; ports clk, rst, run, tick), emitting a one-cycle tick at the last cycle of each bit period; counter clears while run=0.
- Top level holds FSM, 8-bit shift register, bit index.

## Test plan
- Reset: assert rst mid-simulation with no clk edge → tx=1, ready=1, busy=0 immediately; hold 5 cycles, outputs unchanged.
- Single byte, N=4: en=1, d=8'hA5 for one cycle → tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; ready low exactly 40 cycles.
- Back-to-back, N=4: bytes 8'h00 then 8'hFF with en held high → second start bit begins 1 cycle after first stop bit ends; line decodes 00, FF.
- Ignored load: during frame for 8'h3C, pulse en with d=8'hC3 → transmitted byte remains 8'h3C, no second frame started.
- Reset mid-frame: reset during data bit 3 of 8'h55 → tx=1 immediately, ready=1; next load of 8'h81 produces a clean full frame.
- Minimum rate N=2: byte 8'h01 → frame 20 cycles, bit periods exactly 2 cycles each.
